// File: rtl/countdown_pkg.sv
// Shared types, limits and binary-to-BCD helpers for the countdown timer.
package countdown_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StPaused,
        StDone
    } state_t;

    typedef logic [3:0] bcd_t;

    localparam int unsigned MAX_HOUR   = 23;
    localparam int unsigned MAX_MIN    = 59;
    localparam int unsigned MAX_SEC    = 59;
    localparam int unsigned MAX_MS     = 999;
    localparam int unsigned PRESCALE_W = 17;

    // Two-digit BCD of a 0..99 binary value.
    function automatic logic [7:0] bin2bcd2(input logic [6:0] v);
        bcd_t tens;
        bcd_t units;
        tens  = bcd_t'(v / 7'd10);
        units = bcd_t'(v % 7'd10);
        return {tens, units};
    endfunction

    // Milliseconds shown as hundreds and tens digits; the units digit is not displayed.
    function automatic logic [7:0] ms2bcd(input logic [9:0] v);
        logic [9:0] cs;
        cs = v / 10'd10;
        return {bcd_t'(cs / 10'd10), bcd_t'(cs % 10'd10)};
    endfunction

endpackage

// File: rtl/countdown_timer_tick_gen.sv
// 1 ms prescaler: counts 0..TICK_DIV-1 while enabled and flags the terminal count.
module tick_gen
    import countdown_pkg::*;
#(
    parameter int unsigned TICK_DIV = 50000
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic enable_i,
    input  logic clear_i,
    output logic tick_o
);

    localparam logic [PRESCALE_W-1:0] Last = PRESCALE_W'(TICK_DIV - 1);

    logic [PRESCALE_W-1:0] cnt_q, cnt_d;

    assign tick_o = enable_i && (cnt_q == Last);

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (enable_i) begin
            cnt_d = tick_o ? '0 : cnt_q + PRESCALE_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/countdown_timer.sv
// BCD hh:mm:ss countdown at 1 ms resolution with done flag and preset validation.
// Optional alarm pulse after completion is compiled in with COUNTDOWN_ALARM_EN.
module countdown_timer
    import countdown_pkg::*;
#(
    parameter int unsigned TICK_DIV = 50000,
    parameter int unsigned ALARM_MS = 3000
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       load_i,
    input  logic       start_i,
    input  logic       pause_i,
    input  logic [3:0] set_hour_tens_i,
    input  logic [3:0] set_hour_units_i,
    input  logic [3:0] set_min_tens_i,
    input  logic [3:0] set_min_units_i,
    input  logic [3:0] set_sec_tens_i,
    input  logic [3:0] set_sec_units_i,
    output logic [3:0] hour_tens_o,
    output logic [3:0] hour_units_o,
    output logic [3:0] min_tens_o,
    output logic [3:0] min_units_o,
    output logic [3:0] sec_tens_o,
    output logic [3:0] sec_units_o,
    output logic [3:0] milli_sec_tens_o,
    output logic [3:0] milli_sec_units_o,
    output logic       done_o,
    output logic       load_err_o,
    output logic       alarm_o
);

    state_t      state_q, state_d;
    logic [9:0]  ms_q, ms_d;
    logic [5:0]  sec_q, sec_d;
    logic [5:0]  min_q, min_d;
    logic [4:0]  hour_q, hour_d;
    logic [31:0] disp_q, disp_d;
    logic        done_q, load_err_q, load_err_d;

    logic [7:0]  hour_val;
    logic [5:0]  min_val, sec_val;
    logic        preset_ok, load_ok, time_zero, tick, tick_en;

    // min/sec values may overflow for bad digits, but are only used when preset_ok
    assign hour_val = {4'd0, set_hour_tens_i} * 8'd10 + {4'd0, set_hour_units_i};
    assign min_val  = {2'd0, set_min_tens_i} * 6'd10 + {2'd0, set_min_units_i};
    assign sec_val  = {2'd0, set_sec_tens_i} * 6'd10 + {2'd0, set_sec_units_i};

    assign preset_ok = (set_hour_tens_i <= 4'd9) && (set_hour_units_i <= 4'd9) &&
                       (set_min_tens_i <= 4'd5) && (set_min_units_i <= 4'd9) &&
                       (set_sec_tens_i <= 4'd5) && (set_sec_units_i <= 4'd9) &&
                       (hour_val <= 8'(MAX_HOUR));
    assign load_ok   = load_i && (state_q != StRun) && preset_ok;
    assign time_zero = ({hour_q, min_q, sec_q, ms_q} == '0);

`ifdef COUNTDOWN_ALARM_EN
    assign tick_en = ((state_q == StRun) && !pause_i) || (state_q == StDone);
`else
    assign tick_en = (state_q == StRun) && !pause_i;
`endif

    tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .enable_i (tick_en),
        .clear_i  (load_ok),
        .tick_o   (tick)
    );

    always_comb begin
        state_d    = state_q;
        ms_d       = ms_q;
        sec_d      = sec_q;
        min_d      = min_q;
        hour_d     = hour_q;
        load_err_d = 1'b0;
        if (load_i && (state_q != StRun)) begin
            if (preset_ok) begin
                ms_d    = '0;
                sec_d   = sec_val;
                min_d   = min_val;
                hour_d  = hour_val[4:0];
                state_d = StIdle;
            end else begin
                load_err_d = 1'b1;
            end
        end else if (pause_i && (state_q == StRun)) begin
            state_d = StPaused;
        end else if (start_i && ((state_q == StIdle) || (state_q == StPaused))) begin
            state_d = time_zero ? StDone : StRun;
        end else if ((state_q == StRun) && tick) begin
            // Borrow chain; RUN never holds zero time, so hour cannot underflow
            if (ms_q != '0) begin
                ms_d = ms_q - 10'd1;
            end else begin
                ms_d = 10'(MAX_MS);
                if (sec_q != '0) begin
                    sec_d = sec_q - 6'd1;
                end else begin
                    sec_d = 6'(MAX_SEC);
                    if (min_q != '0) begin
                        min_d = min_q - 6'd1;
                    end else begin
                        min_d  = 6'(MAX_MIN);
                        hour_d = hour_q - 5'd1;
                    end
                end
            end
            if ({hour_d, min_d, sec_d, ms_d} == '0) begin
                state_d = StDone;
            end
        end
        disp_d = {bin2bcd2({2'b0, hour_d}), bin2bcd2({1'b0, min_d}),
                  bin2bcd2({1'b0, sec_d}), ms2bcd(ms_d)};
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= StIdle;
            ms_q       <= '0;
            sec_q      <= '0;
            min_q      <= '0;
            hour_q     <= '0;
            disp_q     <= '0;
            done_q     <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ms_q       <= ms_d;
            sec_q      <= sec_d;
            min_q      <= min_d;
            hour_q     <= hour_d;
            disp_q     <= disp_d;
            done_q     <= (state_d == StDone);
            load_err_q <= load_err_d;
        end
    end

`ifdef COUNTDOWN_ALARM_EN
    localparam int unsigned AlarmW = $clog2(ALARM_MS + 1);

    logic [AlarmW-1:0] alarm_cnt_q, alarm_cnt_d;
    logic              alarm_q, alarm_d;

    always_comb begin
        alarm_d     = alarm_q;
        alarm_cnt_d = alarm_cnt_q;
        if ((state_q == StDone) && tick && (alarm_cnt_q != '0)) begin
            alarm_cnt_d = alarm_cnt_q - AlarmW'(1);
            if (alarm_cnt_q == AlarmW'(1)) begin
                alarm_d = 1'b0;
            end
        end
        if ((state_d == StDone) && (state_q != StDone)) begin
            alarm_d     = 1'b1;
            alarm_cnt_d = AlarmW'(ALARM_MS);
        end
        if (load_ok) begin
            alarm_d     = 1'b0;
            alarm_cnt_d = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            alarm_q     <= 1'b0;
            alarm_cnt_q <= '0;
        end else begin
            alarm_q     <= alarm_d;
            alarm_cnt_q <= alarm_cnt_d;
        end
    end

    assign alarm_o = alarm_q;
`else
    logic unused_alarm_ms;
    assign unused_alarm_ms = (ALARM_MS == 0);
    assign alarm_o         = 1'b0;
`endif

    assign {hour_tens_o, hour_units_o, min_tens_o, min_units_o,
            sec_tens_o, sec_units_o, milli_sec_tens_o, milli_sec_units_o} = disp_q;
    assign done_o     = done_q;
    assign load_err_o = load_err_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Bench for countdown_timer: directed plan steps plus random pulses against a total-ms model.
module tb_countdown_timer;

    localparam int TD  = 4;
    localparam int AMS = 5;
    localparam int IDLE = 0, RUN = 1, PAUSED = 2, DONE = 3;
`ifdef COUNTDOWN_ALARM_EN
    localparam bit AlarmEn = 1'b1;
`else
    localparam bit AlarmEn = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic load = 1'b0, start = 1'b0, pause = 1'b0;
    logic [3:0] p_ht = '0, p_hu = '0, p_mt = '0, p_mu = '0, p_st = '0, p_su = '0;
    logic [3:0] ht, hu, mt, mu, st, su, mst, msu;
    logic done, lerr, alarm;
    logic [34:0] dut_vec;

    int checks = 0;
    int errors = 0;

    int m_st = IDLE;
    int m_rem = 0;
    int m_ph = 0;
    int m_acnt = 0;
    bit m_err = 1'b0;
    bit m_alarm = 1'b0;

    always #5 clk = ~clk;

    countdown_timer #(
        .TICK_DIV (TD),
        .ALARM_MS (AMS)
    ) dut (
        .clk_i             (clk),
        .rst_ni            (rst_n),
        .load_i            (load),
        .start_i           (start),
        .pause_i           (pause),
        .set_hour_tens_i   (p_ht),
        .set_hour_units_i  (p_hu),
        .set_min_tens_i    (p_mt),
        .set_min_units_i   (p_mu),
        .set_sec_tens_i    (p_st),
        .set_sec_units_i   (p_su),
        .hour_tens_o       (ht),
        .hour_units_o      (hu),
        .min_tens_o        (mt),
        .min_units_o       (mu),
        .sec_tens_o        (st),
        .sec_units_o       (su),
        .milli_sec_tens_o  (mst),
        .milli_sec_units_o (msu),
        .done_o            (done),
        .load_err_o        (lerr),
        .alarm_o           (alarm)
    );

    assign dut_vec = {ht, hu, mt, mu, st, su, mst, msu, done, lerr, alarm};

    function automatic logic [31:0] digits(input int r);
        int h, mi, s, ms;
        h  = r / 3600000;
        mi = (r / 60000) % 60;
        s  = (r / 1000) % 60;
        ms = r % 1000;
        return {4'(h / 10), 4'(h % 10), 4'(mi / 10), 4'(mi % 10),
                4'(s / 10), 4'(s % 10), 4'(ms / 100), 4'((ms / 10) % 10)};
    endfunction

    function automatic logic [34:0] exp_vec();
        return {digits(m_rem), (m_st == DONE), m_err, m_alarm};
    endfunction

    task automatic check(input string tag, input logic [34:0] obs, input logic [34:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_st = IDLE; m_rem = 0; m_ph = 0; m_acnt = 0; m_err = 1'b0; m_alarm = 1'b0;
    endtask

    task automatic model_step(input bit ld, input bit sta, input bit pa);
        int nst, hv, mv, sv;
        bit valid, accepted, en, tk;
        nst = m_st;
        accepted = 1'b0;
        m_err = 1'b0;
        hv = int'(p_ht) * 10 + int'(p_hu);
        mv = int'(p_mt) * 10 + int'(p_mu);
        sv = int'(p_st) * 10 + int'(p_su);
        valid = (p_ht <= 9) && (p_hu <= 9) && (p_mt <= 5) && (p_mu <= 9) &&
                (p_st <= 5) && (p_su <= 9) && (hv <= 23);
        en = ((m_st == RUN) && !pa) || (AlarmEn && (m_st == DONE));
        tk = en && (m_ph == TD - 1);
        if (ld && (m_st != RUN)) begin
            if (valid) begin
                m_rem = hv * 3600000 + mv * 60000 + sv * 1000;
                nst = IDLE;
                accepted = 1'b1;
            end else begin
                m_err = 1'b1;
            end
        end else if (pa && (m_st == RUN)) begin
            nst = PAUSED;
        end else if (sta && ((m_st == IDLE) || (m_st == PAUSED))) begin
            nst = (m_rem == 0) ? DONE : RUN;
        end else if ((m_st == RUN) && tk) begin
            m_rem--;
            if (m_rem == 0) nst = DONE;
        end
        if (AlarmEn) begin
            if ((m_st == DONE) && tk && (m_acnt > 0)) begin
                m_acnt--;
                if (m_acnt == 0) m_alarm = 1'b0;
            end
            if ((nst == DONE) && (m_st != DONE)) begin
                m_alarm = 1'b1;
                m_acnt = AMS;
            end
            if (accepted) begin
                m_alarm = 1'b0;
                m_acnt = 0;
            end
        end
        if (accepted) m_ph = 0;
        else if (en) m_ph = tk ? 0 : m_ph + 1;
        m_st = nst;
    endtask

    task automatic cyc(input bit ld, input bit sta, input bit pa);
        load = ld; start = sta; pause = pa;
        @(posedge clk);
        model_step(ld, sta, pa);
        #1;
        check("cycle", dut_vec, exp_vec());
        load = 1'b0; start = 1'b0; pause = 1'b0;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0);
    endtask

    task automatic preset(input int h, input int m, input int s);
        p_ht = 4'(h / 10); p_hu = 4'(h % 10);
        p_mt = 4'(m / 10); p_mu = 4'(m % 10);
        p_st = 4'(s / 10); p_su = 4'(s % 10);
    endtask

    task automatic async_reset(input string tag);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check(tag, dut_vec, 35'd0);
        @(posedge clk);
        #2 rst_n = 1'b1;
    endtask

    initial begin
        #1 rst_n = 1'b0;
        #2;
        check("reset_state", dut_vec, 35'd0);
        model_reset();
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;

        // 2 s countdown: first decrement after TD cycles, done after 2000*TD
        preset(0, 0, 2);
        cyc(1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0);
        run(4);
        check("first_tick", 35'(dut_vec[34:3]), 35'(32'h0000_0199));
        run(7995);
        check("done_not_early", 35'(dut_vec[2]), 35'd0);
        run(1);
        check("done_on_time", 35'(dut_vec[2]), 35'd1);
        check("zero_at_done", 35'(dut_vec[34:3]), 35'd0);
`ifdef COUNTDOWN_ALARM_EN
        run(TD * AMS - 1);
        check("alarm_held", 35'(alarm), 35'd1);
        run(1);
        check("alarm_dropped", 35'(alarm), 35'd0);
`else
        check("alarm_tied_low", 35'(alarm), 35'd0);
`endif

        // Full borrow chain from 01:00:00
        preset(1, 0, 0);
        cyc(1'b1, 1'b0, 1'b0);
        check("load_leaves_done", 35'(dut_vec[2]), 35'd0);
        cyc(1'b0, 1'b1, 1'b0);
        run(4);
        check("borrow_chain", 35'(dut_vec[34:3]), 35'(32'h0059_5999));

        // Pause at 1.500 with prescaler mid-phase, then resume
        cyc(1'b0, 1'b0, 1'b1);
        preset(0, 0, 2);
        cyc(1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0);
        run(2002);
        check("pause_point", 35'(dut_vec[34:3]), 35'(32'h0000_0150));
        cyc(1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 100; i++) begin
            cyc(1'b0, 1'b0, 1'b0);
            check("frozen", 35'(dut_vec[34:3]), 35'(32'h0000_0150));
        end
        cyc(1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
        check("phase_kept", 35'(dut_vec[34:3]), 35'(32'h0000_0150));
        cyc(1'b0, 1'b0, 1'b0);
        check("resume_tick", 35'(dut_vec[34:3]), 35'(32'h0000_0149));

        // Rejected preset while paused
        cyc(1'b0, 1'b0, 1'b1);
        preset(0, 0, 0);
        p_mt = 4'd6;
        cyc(1'b1, 1'b0, 1'b0);
        check("load_err_pulse", 35'(lerr), 35'd1);
        check("err_keeps_time", 35'(dut_vec[34:3]), 35'(32'h0000_0149));
        cyc(1'b0, 1'b0, 1'b0);
        check("load_err_single", 35'(lerr), 35'd0);
        cyc(1'b0, 1'b1, 1'b0);
        run(8);

        // load + start together while paused: load wins, stays idle
        cyc(1'b0, 1'b0, 1'b1);
        preset(0, 10, 0);
        cyc(1'b1, 1'b1, 1'b0);
        check("load_wins", 35'(dut_vec[34:3]), 35'(32'h0010_0000));
        run(10);
        check("idle_hold", 35'(dut_vec[34:3]), 35'(32'h0010_0000));

        // Random pulses and presets, including invalid digits
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 31) == 0) begin
                if ($urandom_range(0, 5) == 0) begin
                    p_ht = 4'($urandom_range(0, 15)); p_hu = 4'($urandom_range(0, 15));
                    p_mt = 4'($urandom_range(0, 15)); p_mu = 4'($urandom_range(0, 15));
                    p_st = 4'($urandom_range(0, 15)); p_su = 4'($urandom_range(0, 15));
                end else begin
                    preset(0, 0, int'($urandom_range(0, 2)));
                end
            end
            cyc($urandom_range(0, 47) == 0, $urandom_range(0, 15) == 0,
                $urandom_range(0, 47) == 0);
        end

        // Asynchronous reset mid-run, then start with zero time
        cyc(1'b0, 1'b0, 1'b1);
        preset(0, 0, 5);
        cyc(1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0);
        run(50);
        async_reset("reset_mid_run");
        run(20);
        check("idle_zero", 35'(dut_vec[34:2]), 35'd0);
        cyc(1'b0, 1'b1, 1'b0);
        check("start_at_zero", 35'(dut_vec[2]), 35'd1);
        run(3);
        async_reset("reset_in_done");
        run(5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/countdown_timer.md
# countdown_timer

Countdown timer: loads a BCD preset time (hh:mm:ss), decrements it at 1 ms resolution down to 00:00:00.000, then flags completion. It is the down-counting counterpart of the stopwatch. Its digit outputs use the same eight-digit format, so the existing 7-segment display path consumes them unchanged. It sits between the board switches/keys (preset, start, pause, load) and the display mux.

## Interface
- TICK_DIV, default 50000: clk cycles per 1 ms tick (50 MHz clock).
- ALARM_MS, default 3000: alarm duration in ms (used only when the alarm feature is compiled in).
- clk  in  1: system clock, rising edge.
- reset  in  1: asynchronous, active-low; clears all state.
- load  in  1: single-cycle pulse; latches the preset.
- start  in  1: single-cycle pulse; begins or resumes counting.
- pause  in  1: single-cycle pulse; freezes counting.
- set_hour_tens, set_hour_units, set_min_tens, set_min_units, set_sec_tens, set_sec_units  in  4 each: BCD preset digits.
- hour_tens, hour_units, min_tens, min_units, sec_tens, sec_units, milli_sec_tens, milli_sec_units  out  4 each: BCD remaining time.
  - milli_sec_tens is ms/100; milli_sec_units is (ms/10)%10.
- done  out  1: high while in DONE.
- load_err  out  1: one-cycle pulse on a rejected preset.
- alarm  out  1: alarm output.

## Operation
- Internal binary registers:
  - ms 0..999 (10 b), sec 0..59 (6 b), min 0..59 (6 b), hour 0..23 (5 b).
  - Prescaler 0..TICK_DIV-1 (17 b).
- FSM states: IDLE, RUN, PAUSED, DONE. Reset state is IDLE.
- Input priority in the same cycle: load > pause > start.
- load:
  - Accepted only in IDLE, PAUSED or DONE; ignored in RUN.
  - Preset is valid iff every digit ≤ 9, hour ≤ 23, min_tens ≤ 5 and sec_tens ≤ 5.
  - Valid preset: ms=0, time registers set from the preset, prescaler cleared, alarm cleared, next state IDLE.
  - Invalid preset: registers unchanged, load_err=1 for one cycle, state unchanged.
- start:
  - From IDLE or PAUSED: go to RUN.
  - If time is already all zero: go to DONE on the next edge instead.
  - Ignored in RUN and DONE.
- pause: from RUN, go to PAUSED; prescaler and time are frozen. Ignored in other states.
- RUN behaviour:
  - The prescaler increments each cycle. At TICK_DIV-1 it wraps to 0 and issues a tick.
  - On a tick, borrow-chain decrement: ms-1. If ms=0 then ms=999 and borrow into sec. Sec borrow gives 59 and borrows into min; min borrow gives 59 and borrows into hour.
  - When the decrement produces 00:00:00.000, next state is DONE in that same edge. There is no wrap below zero.
- DONE: time is held at zero and done=1. Exit only via load (to IDLE) or reset.
- Digit outputs are registered from the binary registers' next values. Displayed digits always match the internal time in the same cycle, with no one-tick lag.
- Reset values: all digits 0, done=0, load_err=0, alarm=0, state IDLE, all counters 0.

## Timing
- First decrement occurs exactly TICK_DIV cycles after the edge that enters RUN; the prescaler starts from 0 or from its paused value.
- Pause/resume preserves the prescaler phase, so no sub-ms time is lost.
- done rises on the same edge that the outputs show all zeros.
- load_err pulses on the edge after the load cycle.
- Reset assertion mid-count: all outputs clear asynchronously. On deassertion the block resumes in IDLE with zero time.

## Configuration
- COUNTDOWN_ALARM_EN defined:
  - On entry to DONE, alarm=1 for ALARM_MS ticks. The 1 ms prescaler keeps running in DONE to time this.
  - alarm then drops to 0.
  - load or reset clears alarm immediately.
- COUNTDOWN_ALARM_EN undefined: alarm is tied to 0 and there is no alarm counter logic.

## Structure
- Package countdown_pkg holds:
  - state_t enum (IDLE, RUN, PAUSED, DONE).
  - bcd_t (logic [3:0]).
  - MAX_HOUR=23, MAX_MIN=59, MAX_SEC=59, MAX_MS=999.
- Sub-module tick_gen (prescaler): inputs clk, reset, enable, clear; output tick. Parameterised by TICK_DIV.
- Binary-to-BCD conversion for the outputs is a package function.

## Test plan
- With TICK_DIV=4: load 00:00:02, start.
  - Required: outputs show 00:00:01.99x after 4 cycles.
  - done=1 exactly 2000×4 cycles after start, and outputs are all zero at that point.
- Preset 01:00:00, run one tick.
  - Required: 00:59:59.999, verifying the full borrow chain.
- Pause at 00:00:01.500 for 100 cycles, then start.
  - Required: outputs are frozen during the pause; the next decrement lands on the preserved prescaler phase.
- Load with set_min_tens=6.
  - Required: load_err pulses once; time and state are unchanged.
- Simultaneous load+start in PAUSED.
  - Required: load wins; state is IDLE with the new preset.
- Reset pulse (active low) mid-RUN.
  - Required: all digits 0, state IDLE.
  - With COUNTDOWN_ALARM_EN and ALARM_MS=5: alarm is high for exactly 5 ticks after done, and reset clears it.
